// File: rtl/cubehash_pkg.sv
// CubeHash round scheduler shared types: state encoding, default round counts, index width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cubehash_pkg;

    // Round index / round counter width; round parameters must lie in 1..63.
    localparam int RIDX_W = 6;

    localparam int DEF_INIT_ROUNDS = 16;
    localparam int DEF_BLK_ROUNDS  = 16;
    localparam int DEF_FIN_ROUNDS  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_INIT,
        ST_WAIT_BLK,
        ST_ABSORB,
        ST_FIN_XOR,
        ST_FINAL,
        ST_DONE
    } sched_state_t;

endpackage

// File: rtl/cubehash_round_sched_if.sv
// Control bundle between the CubeHash round scheduler and its datapath/host.
// Latency: n/a (wires only).
// Backpressure: blocks use blk_valid/blk_ready; the hash is held until hash_ack.
// Modports: master = host side (drives start/blocks/ack), slave = scheduler.
interface cubehash_round_sched_if;
    import cubehash_pkg::*;

    logic              start;
    logic              blk_valid;
    logic              blk_last;
    logic              blk_ready;
    logic              init_load;
    logic              round_en;
    logic              xor_blk;
    logic              xor_fin;
    logic [RIDX_W-1:0] round_idx;
    logic              busy;
    logic              hash_valid;
    logic              hash_ack;
    logic              err;

    modport master (
        output start, blk_valid, blk_last, hash_ack,
        input  blk_ready, init_load, round_en, xor_blk, xor_fin,
               round_idx, busy, hash_valid, err
    );

    modport slave (
        input  start, blk_valid, blk_last, hash_ack,
        output blk_ready, init_load, round_en, xor_blk, xor_fin,
               round_idx, busy, hash_valid, err
    );

endinterface

// File: rtl/cubehash_round_ctr.sv
// Round counter: clears on load, increments on enable, saturates at limit; tc flags cnt == limit.
// Latency: count updates one cycle after en; tc is combinational from the count.
// Backpressure: none; the owner decides when to enable or clear.
// Ports: clk, rst_n (sync, active low), load, en, limit -> cnt, tc.
module cubehash_round_ctr
    import cubehash_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [RIDX_W-1:0] limit,
    output logic [RIDX_W-1:0] cnt,
    output logic              tc
);

    assign tc = (cnt == limit);

    // Holding at the limit keeps a late enable from spilling into the next phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cubehash_round_sched.sv
// CubeHash message scheduler: sequences IV load, init rounds, block absorb, finalisation, hash hand-off.
// Latency: start -> init_load next cycle; each round phase lasts its parameter count in cycles.
// Backpressure: blk_ready only while waiting for a block; hash_valid held until hash_ack.
// Ports: clk, rst_n (sync, active low), bus (cubehash_round_sched_if.slave).
// Build option: CUBEHASH_PRECOMP_IV_EN skips the init rounds (init_load selects a precomputed IV).
module cubehash_round_sched
    import cubehash_pkg::*;
#(
    parameter int INIT_ROUNDS = DEF_INIT_ROUNDS,
    parameter int BLK_ROUNDS  = DEF_BLK_ROUNDS,
    parameter int FIN_ROUNDS  = DEF_FIN_ROUNDS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cubehash_round_sched_if.slave  bus
);

    sched_state_t      state;
    logic              blk_last_q;
    logic              init_load_q;
    logic              round_en_q;
    logic              xor_fin_q;
    logic              blk_ready_q;
    logic              busy_q;
    logic              hash_valid_q;
    logic              err_q;

    logic [RIDX_W-1:0] limit;
    logic [RIDX_W-1:0] cnt;
    logic              tc;

    always_comb begin
        limit = '0;
        case (state)
            ST_INIT:   limit = RIDX_W'(INIT_ROUNDS - 1);
            ST_ABSORB: limit = RIDX_W'(BLK_ROUNDS - 1);
            ST_FINAL:  limit = RIDX_W'(FIN_ROUNDS - 1);
            default:   limit = '0;
        endcase
    end

    // round_en_q is high exactly in the round phases, so it doubles as the counter enable;
    // clearing on the last round leaves round_idx at 0 outside the round phases.
    cubehash_round_ctr u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (round_en_q && tc),
        .en    (round_en_q),
        .limit (limit),
        .cnt   (cnt),
        .tc    (tc)
    );

    // Outputs are registered alongside the state: each transition sets the flags of the state entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            blk_last_q   <= 1'b0;
            init_load_q  <= 1'b0;
            round_en_q   <= 1'b0;
            xor_fin_q    <= 1'b0;
            blk_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            hash_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            init_load_q <= 1'b0;
            xor_fin_q   <= 1'b0;
            err_q       <= bus.start && (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state       <= ST_LOAD;
                        init_load_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_LOAD: begin
`ifdef CUBEHASH_PRECOMP_IV_EN
                    state       <= ST_WAIT_BLK;
                    blk_ready_q <= 1'b1;
`else
                    state      <= ST_INIT;
                    round_en_q <= 1'b1;
`endif
                end
                ST_INIT: begin
                    if (tc) begin
                        state       <= ST_WAIT_BLK;
                        round_en_q  <= 1'b0;
                        blk_ready_q <= 1'b1;
                    end
                end
                ST_WAIT_BLK: begin
                    if (bus.blk_valid) begin
                        state       <= ST_ABSORB;
                        blk_last_q  <= bus.blk_last;
                        blk_ready_q <= 1'b0;
                        round_en_q  <= 1'b1;
                    end
                end
                ST_ABSORB: begin
                    if (tc) begin
                        round_en_q <= 1'b0;
                        if (blk_last_q) begin
                            state     <= ST_FIN_XOR;
                            xor_fin_q <= 1'b1;
                        end else begin
                            state       <= ST_WAIT_BLK;
                            blk_ready_q <= 1'b1;
                        end
                    end
                end
                ST_FIN_XOR: begin
                    state      <= ST_FINAL;
                    round_en_q <= 1'b1;
                end
                ST_FINAL: begin
                    if (tc) begin
                        state        <= ST_DONE;
                        round_en_q   <= 1'b0;
                        hash_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.hash_ack) begin
                        state        <= ST_IDLE;
                        hash_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    round_en_q   <= 1'b0;
                    blk_ready_q  <= 1'b0;
                    busy_q       <= 1'b0;
                    hash_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.init_load  = init_load_q;
    assign bus.round_en   = round_en_q;
    assign bus.xor_fin    = xor_fin_q;
    assign bus.blk_ready  = blk_ready_q;
    assign bus.busy       = busy_q;
    assign bus.hash_valid = hash_valid_q;
    assign bus.err        = err_q;
    assign bus.round_idx  = cnt;
    // Same-cycle accept strobe so the datapath XORs the block while it is presented.
    assign bus.xor_blk    = bus.blk_valid && blk_ready_q;

endmodule
